// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: mult/multu/div/divu into HI/LO,
// plus mthi/mtlo writes. Busy holds for a fixed latency per op class.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic        MTHI,
  input  logic        MTLO,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_lo_q, res_hi_d, res_lo_d;
  logic        upd_q, upd_d;
  logic [31:0] hi_d, lo_d;

  logic               sgn;
  logic signed [63:0] a_ext, b_ext, prod;
  logic [63:0]        div_res;

  // Divide on magnitudes so the most-negative dividend needs no special case;
  // a zero divisor yields zeros that the caller never commits.
  function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_signed);
    logic [31:0] ma, mb, q, r;
    logic        neg_q, neg_r;
    neg_r = is_signed & a[31];
    neg_q = is_signed & (a[31] ^ b[31]);
    ma    = neg_r ? -a : a;
    mb    = (is_signed & b[31]) ? -b : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_q) q = -q;
    if (neg_r) r = -r;
    return {r, q};
  endfunction

  // MDOp[0]=0 selects the signed variant for both multiply and divide.
  assign sgn     = ~MDOp[0];
  assign a_ext   = {{32{sgn & A[31]}}, A};
  assign b_ext   = {{32{sgn & B[31]}}, B};
  assign prod    = a_ext * b_ext;
  assign div_res = divide(A, B, sgn);

  assign Busy = (state_q == BUSY);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    upd_d    = upd_q;
    hi_d     = HI;
    lo_d     = LO;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = BUSY;
          if (MDOp[1]) begin
            cnt_d    = DIV_CNT;
            res_hi_d = div_res[63:32];
            res_lo_d = div_res[31:0];
            upd_d    = (B != 32'd0);
          end else begin
            cnt_d    = MULT_CNT;
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
            upd_d    = 1'b1;
          end
        end else begin
          if (MTHI) hi_d = A;
          if (MTLO) lo_d = A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (upd_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      upd_q    <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      upd_q    <= upd_d;
      HI       <= hi_d;
      LO       <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares whenever Busy falls.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic        Start;
  logic [1:0]  MDOp;
  logic        MTHI, MTLO;
  logic        Busy;
  logic [31:0] HI, LO;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Start(Start), .MDOp(MDOp),
    .MTHI(MTHI), .MTLO(MTLO), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_hi, m_lo;
  int          errors = 0;
  int          checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain SV integer arithmetic; returns {HI,LO}.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] cur_hi,
                                         input logic [31:0] cur_lo);
    longint          sa64, sb64;
    longint unsigned ua64, ub64;
    int              sa, sb, q, r;
    logic [31:0]     uq, ur;
    case (op)
      2'd0: begin
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        return 64'(sa64 * sb64);
      end
      2'd1: begin
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        return ua64 * ub64;
      end
      2'd2: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] r;
    r     = ref_op(op, a, b, m_hi, m_lo);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.cyc = op[1] ? 10 : 5;
    sbq.push_back(e);
    m_hi  = e.hi;
    m_lo  = e.lo;
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    tick();
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    MDOp  = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 40) begin
      tick();
      n++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: Busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic mt(input logic hi, input logic lo, input logic [31:0] a);
    MTHI = hi;
    MTLO = lo;
    A    = a;
    tick();
    MTHI = 1'b0;
    MTLO = 1'b0;
    if (hi) m_hi = a;
    if (lo) m_lo = a;
    check32("mt_hi", HI, m_hi);
    check32("mt_lo", LO, m_lo);
  endtask

  // Monitor: one scoreboard entry per Busy falling edge.
  logic prev_busy = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_busy = 1'b0;
      bcnt      = 0;
    end else begin
      if (Busy) bcnt++;
      if (prev_busy && !Busy) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: Busy fell with HI=%h LO=%h, required no completion", HI, LO);
        end else begin
          e = sbq.pop_front();
          check32("sb_hi", HI, e.hi);
          check32("sb_lo", LO, e.lo);
          check32("sb_busy_cycles", 32'(bcnt), 32'(e.cyc));
        end
        bcnt = 0;
      end
      prev_busy = Busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1;
    Start = 1'b0;
    MDOp  = 2'd0;
    MTHI  = 1'b0;
    MTLO  = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    tick();
    tick();
    check32("reset_hi", HI, 32'd0);
    check32("reset_lo", LO, 32'd0);
    check32("reset_busy", 32'(Busy), 32'd0);
    reset = 1'b0;
    tick();

    launch(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle();
    check32("mult_hi", HI, 32'hFFFF_FFFF);
    check32("mult_lo", LO, 32'hFFFF_FFF1);

    launch(2'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    check32("multu_hi", HI, 32'h0000_0001);
    check32("multu_lo", LO, 32'hFFFF_FFFE);

    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check32("div_hi", HI, 32'hFFFF_FFFF);
    check32("div_lo", LO, 32'hFFFF_FFFD);

    launch(2'd3, 32'd7, 32'd2);
    wait_idle();
    check32("divu_hi", HI, 32'd1);
    check32("divu_lo", LO, 32'd3);

    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check32("divovf_hi", HI, 32'd0);
    check32("divovf_lo", LO, 32'h8000_0000);

    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    launch(2'd2, 32'h1234_5678, 32'd0);
    wait_idle();
    check32("div0_hi", HI, 32'h11);
    check32("div0_lo", LO, 32'h22);

    mt(1'b1, 1'b1, 32'hCAFE_F00D);

    // Start wins over a simultaneous mthi/mtlo.
    MTHI = 1'b1;
    MTLO = 1'b1;
    launch(2'd3, 32'd100, 32'd7);
    MTHI = 1'b0;
    MTLO = 1'b0;
    wait_idle();
    check32("startwins_hi", HI, 32'd2);
    check32("startwins_lo", LO, 32'd14);

    // Start/MTHI while busy must be ignored.
    launch(2'd0, 32'd1234, 32'd5678);
    tick();
    Start = 1'b1;
    MDOp  = 2'd3;
    MTHI  = 1'b1;
    A     = 32'hDEAD_BEEF;
    B     = 32'd3;
    tick();
    Start = 1'b0;
    MTHI  = 1'b0;
    wait_idle();
    check32("ignored_lo", LO, 32'd7006652);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      launch(op, ra, rb);
      wait_idle();
    end
    tick();

    // Reset in the middle of a divide discards the pending result.
    launch(2'd2, 32'd1000, 32'd3);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check32("rst_busy", 32'(Busy), 32'd0);
    check32("rst_hi", HI, 32'd0);
    check32("rst_lo", LO, 32'd0);
    sbq.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check32("post_rst_hi", HI, 32'd0);
    check32("post_rst_lo", LO, 32'd0);
    check32("post_rst_busy", 32'(Busy), 32'd0);
    check32("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
